tone_sequencer: RTL

Controller that sequences the PWM tone generator. It plays a programmable melody held in an internal note table and arbitrates it against live keypad input; the live key always has priority. It sits between the keypad/debounce front end and tone_dcdr, and drives that block's note code and duty cycle.

---
 rtl/tone_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// Melody sequencer for tone_dcdr: plays a note table and lets a live key override it.
// Optional macro TONE_SEQ_ACCENT_EN: later beats of a played note use half duty.
module tone_sequencer #(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned GAP_CYCLES = 1_000_000,
  parameter int unsigned SEQ_DEPTH  = 16,
  localparam int unsigned AW        = $clog2(SEQ_DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic [6:0]    duty_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_note,
  input  logic [3:0]    wr_len,
  input  logic          play,
  input  logic          stop,
  input  logic          loop_en,
  output logic [3:0]    tone_code,
  output logic          tone_en,
  output logic [6:0]    duty_cycle,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIVE,
    S_PLAY,
    S_GAP,
    S_PAUSE
  } state_t;

  state_t        state_q, state_d;
  state_t        saved_q, saved_d;
  state_t        run_state;
  logic [AW-1:0] idx_q, idx_d, run_idx, nxt_idx;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    beat_q, beat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          run_end;
  logic          done_d;
  logic [3:0]    code_d;
  logic          en_d;
  logic [6:0]    duty_d;
  logic [6:0]    duty_clamp;
  logic [3:0]    cur_len;
  logic          wr_ok;

  logic [3:0] note_mem [SEQ_DEPTH];
  logic [3:0] len_mem  [SEQ_DEPTH];

  assign nxt_idx    = idx_q + AW'(1);
  assign cur_len    = len_mem[idx_q];
  assign duty_clamp = (duty_in > 7'd100) ? 7'd100 : duty_in;
  assign wr_ok      = wr_en && !busy && (state_q == S_IDLE || state_q == S_LIVE);
  assign step_idx   = idx_q;

  // Note table; contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      note_mem[wr_addr] <= wr_note;
      len_mem[wr_addr]  <= wr_len;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      saved_q    <= S_IDLE;
      idx_q      <= '0;
      tick_q     <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      tone_code  <= '0;
      tone_en    <= 1'b0;
      duty_cycle <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      tone_code  <= code_d;
      tone_en    <= en_d;
      duty_cycle <= duty_d;
      busy       <= (state_d == S_PLAY) || (state_d == S_GAP) || (state_d == S_PAUSE);
      done       <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    run_state = state_q;
    run_idx   = idx_q;
    run_end   = 1'b0;

    // Where the sequence would go this cycle absent keys/stop; counters only move in PLAY/GAP.
    if (state_q == S_PLAY) begin
      if (tick_q == TW'(TICK_DIV - 1)) begin
        tick_d = '0;
        if (beat_q == 4'(cur_len - 4'd1)) begin
          beat_d    = '0;
          gap_d     = '0;
          run_state = S_GAP;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end else if (state_q == S_GAP) begin
      if (gap_q == GW'(GAP_CYCLES - 1)) begin
        gap_d     = '0;
        tick_d    = '0;
        beat_d    = '0;
        run_state = S_PLAY;
        if (idx_q != AW'(SEQ_DEPTH - 1) && len_mem[nxt_idx] != 4'd0) begin
          run_idx = nxt_idx;
        end else if (loop_en && len_mem[0] != 4'd0) begin
          run_idx = '0;
        end else begin
          run_end = 1'b1;
        end
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          state_d = S_LIVE;
        end else if (play && !stop) begin
          idx_d  = '0;
          tick_d = '0;
          beat_d = '0;
          gap_d  = '0;
          if (len_mem[0] == 4'd0) done_d = 1'b1;
          else                    state_d = S_PLAY;
        end
      end
      S_LIVE: begin
        if (!key_valid) state_d = S_IDLE;
      end
      S_PLAY, S_GAP: begin
        if (stop || run_end) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tick_d  = '0;
          beat_d  = '0;
          gap_d   = '0;
          done_d  = 1'b1;
        end else if (key_valid) begin
          state_d = S_PAUSE;
          saved_d = run_state;
          idx_d   = run_idx;
        end else begin
          state_d = run_state;
          idx_d   = run_idx;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tick_d  = '0;
          beat_d  = '0;
          gap_d   = '0;
          done_d  = 1'b1;
        end else if (!key_valid) begin
          state_d = saved_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    code_d = '0;
    en_d   = 1'b0;
    case (state_d)
      S_LIVE, S_PAUSE: begin
        code_d = key_code;
        en_d   = 1'b1;
      end
      S_PLAY: begin
        code_d = note_mem[idx_d];
        en_d   = (note_mem[idx_d] != 4'd0);
      end
      default: ;
    endcase
    duty_d = en_d ? duty_clamp : 7'd0;
`ifdef TONE_SEQ_ACCENT_EN
    if (en_d && state_d == S_PLAY && beat_d != 4'd0) duty_d = duty_clamp >> 1;
`endif
  end

endmodule
